// File: rtl/vend_pkg.sv
// Shared definitions for the parametrised vending controller:
// one-hot state encoding and coin values in 0.5-unit steps.
// Optional 2.0 coin input is enabled by defining VEND_TWO_COIN_EN.
package vend_pkg;

    // One-hot controller states; the bit positions are used to decode outputs.
    typedef enum logic [2:0] {
        ST_IDLE = 3'b001,
        ST_PAY  = 3'b010,
        ST_GAP  = 3'b100
    } state_t;

    localparam int unsigned ST_IDLE_BIT = 0;
    localparam int unsigned ST_PAY_BIT  = 1;
    localparam int unsigned ST_GAP_BIT  = 2;

    // Coin values in 0.5-unit steps.
    localparam logic [2:0] COIN_HALF = 3'd1;
    localparam logic [2:0] COIN_ONE  = 3'd2;
    localparam logic [2:0] COIN_TWO  = 3'd4;

endpackage

// File: rtl/vend_coin_decode.sv
// Coin pulse decoder: turns the acceptor pulses of one cycle into a coin
// value, a "exactly one coin" flag and a "two or more coins" flag.
// The pi_money_two-style input i_money_two exists only with VEND_TWO_COIN_EN.
module vend_coin_decode
    import vend_pkg::*;
(
    input  logic       i_money_half,
    input  logic       i_money_one,
`ifdef VEND_TWO_COIN_EN
    input  logic       i_money_two,
`endif
    output logic [2:0] o_value,
    output logic       o_valid,
    output logic       o_multi,
    output logic       o_any
);

    logic [1:0] w_count;
    logic [2:0] w_raw;

    // Count simultaneous pulses and build the raw value; value is only
    // meaningful when exactly one coin arrived, otherwise it reads as zero.
    always_comb begin
        w_count = 2'd0;
        w_raw   = 3'd0;
        w_count = {1'b0, i_money_half} + {1'b0, i_money_one};
        w_raw   = ({3{i_money_half}} & COIN_HALF) | ({3{i_money_one}} & COIN_ONE);
`ifdef VEND_TWO_COIN_EN
        w_count = w_count + {1'b0, i_money_two};
        w_raw   = w_raw | ({3{i_money_two}} & COIN_TWO);
`endif
        o_any   = (w_count != 2'd0);
        o_valid = (w_count == 2'd1);
        o_multi = (w_count >= 2'd2);
        if (o_valid) begin
            o_value = w_raw;
        end else begin
            o_value = 3'd0;
        end
    end

endmodule

// File: rtl/vend_ctrl_param.sv
// Parametrised vending controller: accumulates credit against PRICE,
// dispenses one product, and pays change/refund as a paced pulse train
// (one po_money pulse every second cycle). Coins arriving while busy or
// several at once are bounced with po_reject.
// Optional feature macro: VEND_TWO_COIN_EN adds the pi_money_two input.
module vend_ctrl_param
    import vend_pkg::*;
#(
    parameter int PRICE    = 5,
    parameter int CREDIT_W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                pi_money_half,
    input  logic                pi_money_one,
`ifdef VEND_TWO_COIN_EN
    input  logic                pi_money_two,
`endif
    input  logic                pi_cancel,
    output logic                po_cola,
    output logic                po_money,
    output logic                po_reject,
    output logic                po_busy,
    output logic [CREDIT_W-1:0] po_credit
);

    localparam logic [CREDIT_W:0]   P_PRICE     = (CREDIT_W+1)'(PRICE);
    localparam logic [CREDIT_W-1:0] CREDIT_ZERO = {CREDIT_W{1'b0}};
    localparam logic [CREDIT_W-1:0] CREDIT_ONE  = {{(CREDIT_W-1){1'b0}}, 1'b1};

    state_t              r_state;
    state_t              w_state_nx;
    logic [CREDIT_W-1:0] r_credit;
    logic [CREDIT_W-1:0] w_credit_nx;
    logic                r_cola;
    logic                w_cola_nx;
    logic                r_reject;
    logic                w_reject_nx;

    logic [2:0]          w_coin_value;
    logic                w_coin_valid;
    logic                w_coin_multi;
    logic                w_coin_any;
    logic [CREDIT_W:0]   w_sum;
    logic [CREDIT_W-1:0] w_rem;

    vend_coin_decode u_coin_decode (
        .i_money_half (pi_money_half),
        .i_money_one  (pi_money_one),
`ifdef VEND_TWO_COIN_EN
        .i_money_two  (pi_money_two),
`endif
        .o_value      (w_coin_value),
        .o_valid      (w_coin_valid),
        .o_multi      (w_coin_multi),
        .o_any        (w_coin_any)
    );

    // Credit plus the incoming coin (zero when no single legal coin), and
    // what is left after paying for one product. PRICE+3 always fits CREDIT_W.
    assign w_sum = {1'b0, r_credit} + (CREDIT_W+1)'(w_coin_value);
    assign w_rem = w_sum[CREDIT_W-1:0] - P_PRICE[CREDIT_W-1:0];

    // Next-state, next-credit and pulse decisions for the one-hot FSM.
    always_comb begin
        w_state_nx  = r_state;
        w_credit_nx = r_credit;
        w_cola_nx   = 1'b0;
        w_reject_nx = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_reject_nx = w_coin_multi;
                if (pi_cancel) begin
                    // A single coin arriving with cancel is credited and refunded too.
                    if (w_sum != {(CREDIT_W+1){1'b0}}) begin
                        w_credit_nx = w_sum[CREDIT_W-1:0];
                        w_state_nx  = ST_PAY;
                    end else begin
                        w_credit_nx = r_credit;
                        w_state_nx  = ST_IDLE;
                    end
                end else if (w_coin_valid) begin
                    if (w_sum >= P_PRICE) begin
                        w_cola_nx   = 1'b1;
                        w_credit_nx = w_rem;
                        // Start change with a spacer so the first coin out
                        // follows the dispense pulse instead of sharing its cycle.
                        if (w_rem != CREDIT_ZERO) begin
                            w_state_nx = ST_GAP;
                        end else begin
                            w_state_nx = ST_IDLE;
                        end
                    end else begin
                        w_credit_nx = w_sum[CREDIT_W-1:0];
                        w_state_nx  = ST_IDLE;
                    end
                end else begin
                    w_state_nx = ST_IDLE;
                end
            end
            ST_PAY: begin
                w_reject_nx = w_coin_any;
                if (r_credit > CREDIT_ONE) begin
                    w_credit_nx = r_credit - CREDIT_ONE;
                    w_state_nx  = ST_GAP;
                end else begin
                    w_credit_nx = CREDIT_ZERO;
                    w_state_nx  = ST_IDLE;
                end
            end
            ST_GAP: begin
                w_reject_nx = w_coin_any;
                w_state_nx  = ST_PAY;
            end
            default: begin
                // Illegal one-hot code: fall back to a clean idle state.
                w_credit_nx = CREDIT_ZERO;
                w_state_nx  = ST_IDLE;
            end
        endcase
    end

    // State, credit and single-cycle pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_credit <= CREDIT_ZERO;
            r_cola   <= 1'b0;
            r_reject <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_credit <= w_credit_nx;
            r_cola   <= w_cola_nx;
            r_reject <= w_reject_nx;
        end
    end

    assign po_cola   = r_cola;
    assign po_reject = r_reject;
    assign po_money  = r_state[ST_PAY_BIT];
    assign po_busy   = ~r_state[ST_IDLE_BIT];
    assign po_credit = r_credit;

endmodule

// File: tb/tb_vend_ctrl_param.sv
// Scoreboard bench for vend_ctrl_param (PRICE=5, CREDIT_W=4).
// Expected outputs are pushed per driven cycle; observed outputs are captured
// 1 time unit after the clock edge and compared inside each scenario task.
module tb_vend_ctrl_param;

    localparam int PRICE    = 5;
    localparam int CREDIT_W = 4;

    typedef struct packed {
        logic                cola;
        logic                money;
        logic                reject;
        logic                busy;
        logic [CREDIT_W-1:0] credit;
    } obs_t;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                pi_money_half = 1'b0;
    logic                pi_money_one = 1'b0;
    logic                pi_money_two = 1'b0;
    logic                pi_cancel = 1'b0;
    logic                po_cola;
    logic                po_money;
    logic                po_reject;
    logic                po_busy;
    logic [CREDIT_W-1:0] po_credit;

    obs_t q_exp[$];
    obs_t q_act[$];
    int   checks = 0;
    int   errors = 0;

    vend_ctrl_param #(.PRICE(PRICE), .CREDIT_W(CREDIT_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pi_money_half (pi_money_half),
        .pi_money_one  (pi_money_one),
`ifdef VEND_TWO_COIN_EN
        .pi_money_two  (pi_money_two),
`endif
        .pi_cancel     (pi_cancel),
        .po_cola       (po_cola),
        .po_money      (po_money),
        .po_reject     (po_reject),
        .po_busy       (po_busy),
        .po_credit     (po_credit)
    );

    always #5 clk = ~clk;

    function automatic obs_t ex(input logic cl, input logic m, input logic r,
                                input logic b, input int cr);
        obs_t e;
        e.cola   = cl;
        e.money  = m;
        e.reject = r;
        e.busy   = b;
        e.credit = CREDIT_W'(cr);
        return e;
    endfunction

    // One stimulus cycle: inputs held for one edge, expectation queued, outputs captured.
    task automatic drive(input logic h, input logic o, input logic t, input logic c,
                         input obs_t e);
        pi_money_half = h;
        pi_money_one  = o;
        pi_money_two  = t;
        pi_cancel     = c;
        q_exp.push_back(e);
        @(posedge clk);
        #1;
        q_act.push_back({po_cola, po_money, po_reject, po_busy, po_credit});
        pi_money_half = 1'b0;
        pi_money_one  = 1'b0;
        pi_money_two  = 1'b0;
        pi_cancel     = 1'b0;
    endtask

    task automatic test_reset;
        obs_t a;
        #12;
        a = {po_cola, po_money, po_reject, po_busy, po_credit};
        checks++;
        if (a !== ex(0, 0, 0, 0, 0)) begin
            errors++;
            $display("FAIL reset_held: got %b want %b", a, ex(0, 0, 0, 0, 0));
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        a = {po_cola, po_money, po_reject, po_busy, po_credit};
        checks++;
        if (a !== ex(0, 0, 0, 0, 0)) begin
            errors++;
            $display("FAIL reset_release: got %b want %b", a, ex(0, 0, 0, 0, 0));
        end
    endtask

    task automatic test_half_coins;
        obs_t e, a;
        int   n = 0;
        for (int k = 1; k <= 4; k++) begin
            drive(1, 0, 0, 0, ex(0, 0, 0, 0, k));
            drive(0, 0, 0, 0, ex(0, 0, 0, 0, k));
            drive(0, 0, 0, 0, ex(0, 0, 0, 0, k));
        end
        drive(1, 0, 0, 0, ex(1, 0, 0, 0, 0));
        drive(0, 0, 0, 0, ex(0, 0, 0, 0, 0));
        drive(0, 0, 0, 0, ex(0, 0, 0, 0, 0));
        while (q_exp.size() != 0) begin
            e = q_exp.pop_front();
            a = q_act.pop_front();
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL half_coins step%0d: got %b want %b", n, a, e);
            end
            n++;
        end
    endtask

    task automatic test_one_coins;
        obs_t e, a;
        int   n = 0;
        drive(0, 1, 0, 0, ex(0, 0, 0, 0, 2));
        drive(0, 0, 0, 0, ex(0, 0, 0, 0, 2));
        drive(0, 1, 0, 0, ex(0, 0, 0, 0, 4));
        drive(0, 0, 0, 0, ex(0, 0, 0, 0, 4));
        drive(0, 1, 0, 0, ex(1, 0, 0, 1, 1));   // dispense, change pending
        drive(0, 0, 0, 0, ex(0, 1, 0, 1, 1));   // single change pulse
        drive(0, 0, 0, 0, ex(0, 0, 0, 0, 0));
        drive(0, 0, 0, 0, ex(0, 0, 0, 0, 0));
        while (q_exp.size() != 0) begin
            e = q_exp.pop_front();
            a = q_act.pop_front();
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL one_coins step%0d: got %b want %b", n, a, e);
            end
            n++;
        end
    endtask

    task automatic test_cancel;
        obs_t e, a;
        int   n = 0;
        drive(0, 0, 0, 1, ex(0, 0, 0, 0, 0));   // cancel with no credit: no effect
        drive(0, 0, 0, 0, ex(0, 0, 0, 0, 0));
        drive(0, 1, 0, 0, ex(0, 0, 0, 0, 2));
        drive(1, 0, 0, 0, ex(0, 0, 0, 0, 3));
        drive(0, 0, 0, 1, ex(0, 1, 0, 1, 3));   // cancel+1
        drive(0, 0, 0, 0, ex(0, 0, 0, 1, 2));
        drive(0, 0, 0, 0, ex(0, 1, 0, 1, 2));   // cancel+3
        drive(0, 0, 0, 0, ex(0, 0, 0, 1, 1));
        drive(0, 0, 0, 0, ex(0, 1, 0, 1, 1));   // cancel+5
        drive(0, 0, 0, 0, ex(0, 0, 0, 0, 0));   // cancel+6: idle again
        while (q_exp.size() != 0) begin
            e = q_exp.pop_front();
            a = q_act.pop_front();
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL cancel step%0d: got %b want %b", n, a, e);
            end
            n++;
        end
    endtask

    task automatic test_multi_coin;
        obs_t e, a;
        int   n = 0;
        drive(1, 0, 0, 0, ex(0, 0, 0, 0, 1));
        drive(1, 1, 0, 0, ex(0, 0, 1, 0, 1));   // two coins at once: bounced
        drive(0, 0, 0, 0, ex(0, 0, 0, 0, 1));
        drive(0, 0, 0, 1, ex(0, 1, 0, 1, 1));   // one-unit refund
        drive(0, 0, 0, 0, ex(0, 0, 0, 0, 0));
        while (q_exp.size() != 0) begin
            e = q_exp.pop_front();
            a = q_act.pop_front();
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL multi_coin step%0d: got %b want %b", n, a, e);
            end
            n++;
        end
    endtask

    task automatic test_cancel_with_coin;
        obs_t e, a;
        int   n = 0;
        drive(0, 1, 0, 0, ex(0, 0, 0, 0, 2));
        drive(0, 1, 0, 0, ex(0, 0, 0, 0, 4));
        // Coin reaches PRICE but cancel wins: full refund of 5, no dispense.
        drive(1, 0, 0, 1, ex(0, 1, 0, 1, 5));
        for (int k = 4; k >= 1; k--) begin
            drive(0, 0, 0, 0, ex(0, 0, 0, 1, k));
            drive(0, 0, 0, 0, ex(0, 1, 0, 1, k));
        end
        drive(0, 0, 0, 0, ex(0, 0, 0, 0, 0));
        while (q_exp.size() != 0) begin
            e = q_exp.pop_front();
            a = q_act.pop_front();
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL cancel_coin step%0d: got %b want %b", n, a, e);
            end
            n++;
        end
    endtask

    task automatic test_busy_reject;
        obs_t e, a;
        int   n = 0;
        drive(0, 1, 0, 0, ex(0, 0, 0, 0, 2));
        drive(1, 0, 0, 0, ex(0, 0, 0, 0, 3));
        drive(0, 0, 0, 1, ex(0, 1, 0, 1, 3));
        drive(1, 0, 0, 0, ex(0, 0, 1, 1, 2));   // coin during PAY
        drive(0, 1, 0, 0, ex(0, 1, 1, 1, 2));   // coin during GAP
        drive(0, 0, 0, 0, ex(0, 0, 0, 1, 1));
        drive(0, 0, 0, 1, ex(0, 1, 0, 1, 1));   // cancel while busy ignored
        drive(0, 0, 0, 0, ex(0, 0, 0, 0, 0));
        while (q_exp.size() != 0) begin
            e = q_exp.pop_front();
            a = q_act.pop_front();
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL busy_reject step%0d: got %b want %b", n, a, e);
            end
            n++;
        end
    endtask

    task automatic test_reset_mid_pay;
        obs_t e, a;
        int   n = 0;
        drive(0, 1, 0, 0, ex(0, 0, 0, 0, 2));
        drive(1, 0, 0, 0, ex(0, 0, 0, 0, 3));
        drive(0, 0, 0, 1, ex(0, 1, 0, 1, 3));
        #2;
        rst_n = 1'b0;
        #1;
        a = {po_cola, po_money, po_reject, po_busy, po_credit};
        checks++;
        if (a !== ex(0, 0, 0, 0, 0)) begin
            errors++;
            $display("FAIL reset_mid_pay: got %b want %b", a, ex(0, 0, 0, 0, 0));
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive(0, 0, 0, 0, ex(0, 0, 0, 0, 0));
        drive(0, 0, 0, 0, ex(0, 0, 0, 0, 0));
        drive(1, 0, 0, 0, ex(0, 0, 0, 0, 1));
        drive(0, 0, 0, 1, ex(0, 1, 0, 1, 1));
        drive(0, 0, 0, 0, ex(0, 0, 0, 0, 0));
        while (q_exp.size() != 0) begin
            e = q_exp.pop_front();
            a = q_act.pop_front();
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL reset_mid step%0d: got %b want %b", n, a, e);
            end
            n++;
        end
    endtask

`ifdef VEND_TWO_COIN_EN
    task automatic test_two_coin;
        obs_t e, a;
        int   n = 0;
        for (int k = 1; k <= 4; k++) begin
            drive(1, 0, 0, 0, ex(0, 0, 0, 0, k));
        end
        drive(0, 0, 1, 0, ex(1, 0, 0, 1, 3));   // 4+4=8: dispense, 3 change
        for (int k = 3; k >= 1; k--) begin
            drive(0, 0, 0, 0, ex(0, 1, 0, 1, k));
            if (k > 1) begin
                drive(0, 0, 0, 0, ex(0, 0, 0, 1, k - 1));
            end
        end
        drive(0, 0, 0, 0, ex(0, 0, 0, 0, 0));
        drive(1, 0, 1, 0, ex(0, 0, 1, 0, 0));   // half+two together: bounced
        while (q_exp.size() != 0) begin
            e = q_exp.pop_front();
            a = q_act.pop_front();
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL two_coin step%0d: got %b want %b", n, a, e);
            end
            n++;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_half_coins();
        test_one_coins();
        test_cancel();
        test_multi_coin();
        test_cancel_with_coin();
        test_busy_reject();
        test_reset_mid_pay();
`ifdef VEND_TWO_COIN_EN
        test_two_coin();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
